// File: rtl/diablo_pkg.sv
// ALU op encodings and the legality check shared by the decoder and the ALU scheduler.
package diablo_pkg;

    localparam logic [6:0] ALU_ADD  = 7'd0;
    localparam logic [6:0] ALU_SUB  = 7'd1;
    localparam logic [6:0] ALU_AND  = 7'd2;
    localparam logic [6:0] ALU_OR   = 7'd3;
    localparam logic [6:0] ALU_XOR  = 7'd4;
    localparam logic [6:0] ALU_SLL  = 7'd5;
    localparam logic [6:0] ALU_SRL  = 7'd6;
    localparam logic [6:0] ALU_SRA  = 7'd7;
    localparam logic [6:0] ALU_SLT  = 7'd8;
    localparam logic [6:0] ALU_SLTU = 7'd9;

    function automatic logic alu_op_legal(input logic [6:0] op);
        return op <= ALU_SLTU;
    endfunction

endpackage

// File: rtl/alu_scheduler_alu.sv
// Purely combinational 32-bit ALU; illegal op codes yield zero with err set.
module alu_scheduler_alu
    import diablo_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        err
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic [4:0]         shamt;

    always_comb begin
        a_s    = $signed(a);
        b_s    = $signed(b);
        shamt  = b[4:0];
        err    = !alu_op_legal(op);
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned(a_s >>> shamt);
            ALU_SLT:  result = {31'd0, a_s < b_s};
            ALU_SLTU: result = {31'd0, a < b};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU between N_REQ requesters with round-robin grant and a single
// registered result slot that can drain and reload in the same cycle.
module alu_scheduler
    import diablo_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int TAG_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][6:0]       req_op,
    input  logic [N_REQ-1:0][31:0]      req_a,
    input  logic [N_REQ-1:0][31:0]      req_b,
    input  logic [N_REQ-1:0][TAG_W-1:0] req_tag,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [31:0]                 rsp_data,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic                        rsp_err,
    output logic [31:0]                 op_count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic             out_valid;
    logic [PTR_W-1:0] owner;
    logic [31:0]      data_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             err_p1;
    logic [PTR_W-1:0] rr_ptr;
    logic [31:0]      count_q;

    logic             drain;
    logic             can_issue;
    logic             issue;
    logic [PTR_W-1:0] grant;
    logic [31:0]      alu_result;
    logic             alu_err;

    always_comb begin
        drain     = out_valid && rsp_ready[owner];
        can_issue = !out_valid || drain;
        issue     = 1'b0;
        grant     = rr_ptr;
        // Scan farthest offset first so the nearest requester after rr_ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                issue = 1'b1;
                grant = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
        issue     = issue && can_issue && !rst;
        req_ready = '0;
        if (issue) req_ready[grant] = 1'b1;
    end

    alu_scheduler_alu u_alu (
        .op     (req_op[grant]),
        .a      (req_a[grant]),
        .b      (req_b[grant]),
        .result (alu_result),
        .err    (alu_err)
    );

    // Stage p1: registered result slot
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            owner     <= '0;
            data_p1   <= '0;
            tag_p1    <= '0;
            err_p1    <= 1'b0;
            rr_ptr    <= '0;
            count_q   <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            owner     <= grant;
            data_p1   <= alu_result;
            tag_p1    <= req_tag[grant];
            err_p1    <= alu_err;
            rr_ptr    <= PTR_W'((int'(grant) + 1) % N_REQ);
            count_q   <= count_q + 32'd1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = out_valid && (owner == PTR_W'(i));
        end
    end

    assign rsp_data = data_p1;
    assign rsp_tag  = tag_p1;
    assign rsp_err  = err_p1;
    assign op_count = count_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: vector table, scoreboard of issued ops, and directed
// back-pressure, contention and reset sequences.
module tb_alu_scheduler;
    import diablo_pkg::*;

    localparam int N_REQ = 2;
    localparam int TAG_W = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0][6:0]       req_op;
    logic [N_REQ-1:0][31:0]      req_a;
    logic [N_REQ-1:0][31:0]      req_b;
    logic [N_REQ-1:0][TAG_W-1:0] req_tag;
    logic [N_REQ-1:0]            rsp_valid;
    logic [N_REQ-1:0]            rsp_ready;
    logic [31:0]                 rsp_data;
    logic [TAG_W-1:0]            rsp_tag;
    logic                        rsp_err;
    logic [31:0]                 op_count;

    alu_scheduler #(.N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU written independently of the RTL's operator choices.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] r;
        s = b[4:0];
        r = 32'd0;
        case (op)
            7'd0: r = a + b;
            7'd1: r = a + ~b + 32'd1;
            7'd2: r = a & b;
            7'd3: r = a | b;
            7'd4: r = a ^ b;
            7'd5: r = a << s;
            7'd6: r = a >> s;
            7'd7: r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            7'd8: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            7'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: return {1'b1, 32'd0};
        endcase
        return {1'b0, r};
    endfunction

    typedef struct {
        int               owner;
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t sb_q[$];

    always @(negedge clk) begin
        exp_t e;
        logic [32:0] m;
        if (rst) begin
            sb_q.delete();
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_owner", 32'(i), 32'(e.owner));
                        check("sb_data", rsp_data, e.data);
                        check("sb_tag", 32'(rsp_tag), 32'(e.tag));
                        check("sb_err", 32'(rsp_err), 32'(e.err));
                    end
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    m = model(req_op[i], req_a[i], req_b[i]);
                    e.owner = i;
                    e.data  = m[31:0];
                    e.tag   = req_tag[i];
                    e.err   = m[32];
                    sb_q.push_back(e);
                end
            end
        end
    end

    typedef struct {
        int               r;
        logic [6:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp_data;
        logic             exp_err;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 2'b11;

        tbl.push_back('{0, ALU_ADD,  32'd5,          32'd7,  4'd3, 32'd12,         1'b0});
        tbl.push_back('{0, ALU_SUB,  32'd3,          32'd5,  4'd4, 32'hFFFF_FFFE,  1'b0});
        tbl.push_back('{1, ALU_ADD,  32'hFFFF_FFFF,  32'd1,  4'd5, 32'd0,          1'b0});
        tbl.push_back('{0, ALU_AND,  32'hF0F0_1234,  32'h0FF0_FFFF, 4'd6, 32'h00F0_1234, 1'b0});
        tbl.push_back('{1, ALU_OR,   32'hF000_0000,  32'h0000_000F, 4'd7, 32'hF000_000F, 1'b0});
        tbl.push_back('{0, ALU_XOR,  32'hAAAA_5555,  32'hFFFF_0000, 4'd8, 32'h5555_5555, 1'b0});
        tbl.push_back('{1, ALU_SLL,  32'd1,          32'd31, 4'd9, 32'h8000_0000,  1'b0});
        tbl.push_back('{0, ALU_SRL,  32'h8000_0000,  32'd33, 4'hA, 32'h4000_0000,  1'b0});
        tbl.push_back('{1, ALU_SRA,  32'h8000_0000,  32'd33, 4'hB, 32'hC000_0000,  1'b0});
        tbl.push_back('{0, ALU_SLT,  32'hFFFF_FFFF,  32'd1,  4'hC, 32'd1,          1'b0});
        tbl.push_back('{0, ALU_SLTU, 32'hFFFF_FFFF,  32'd1,  4'hD, 32'd0,          1'b0});
        tbl.push_back('{1, 7'h7F,    32'd9,          32'd9,  4'hE, 32'd0,          1'b1});

        // Reset state; requests presented during reset must not be accepted.
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_op_count", op_count, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 2'b00;

        // Single-op vectors, one at a time with rsp_ready high.
        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk); #1;
            req_valid[tbl[k].r] = 1'b1;
            req_op[tbl[k].r]    = tbl[k].op;
            req_a[tbl[k].r]     = tbl[k].a;
            req_b[tbl[k].r]     = tbl[k].b;
            req_tag[tbl[k].r]   = tbl[k].tag;
            @(negedge clk);
            check("vec_req_ready", 32'(req_ready), 32'(1 << tbl[k].r));
            @(posedge clk); #1;
            req_valid = 2'b00;
            @(negedge clk);
            check("vec_rsp_valid", 32'(rsp_valid), 32'(1 << tbl[k].r));
            check("vec_data", rsp_data, tbl[k].exp_data);
            check("vec_tag", 32'(rsp_tag), 32'(tbl[k].tag));
            check("vec_err", 32'(rsp_err), 32'(tbl[k].exp_err));
            check("vec_op_count", op_count, 32'(k + 1));
        end

        // Contention: last vector came from requester 1, so rr_ptr is back at 0.
        @(posedge clk); #1;
        req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            req_op[0] = ALU_ADD; req_a[0] = 32'(c); req_b[0] = 32'd100; req_tag[0] = 4'(c);
            req_op[1] = ALU_SUB; req_a[1] = 32'(c); req_b[1] = 32'd1;   req_tag[1] = 4'(c + 8);
            @(negedge clk);
            check("rr_grant", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
            if (c > 0) check("rr_rsp_owner", 32'(rsp_valid), (c % 2 == 0) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        @(posedge clk); #1;

        // Back-pressure on requester 0 with requester 1 waiting behind it.
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        req_op[0] = ALU_SUB; req_a[0] = 32'd3; req_b[0] = 32'd5; req_tag[0] = 4'd2;
        @(posedge clk); #1;
        req_valid = 2'b10;
        req_op[1] = ALU_ADD; req_a[1] = 32'd1; req_b[1] = 32'd2; req_tag[1] = 4'd5;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data_held", rsp_data, 32'hFFFF_FFFE);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check("bp_drain_issue", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("bp_next_owner", 32'(rsp_valid), 32'd2);
        check("bp_next_data", rsp_data, 32'd3);
        check("bp_next_tag", 32'(rsp_tag), 32'd5);
        @(posedge clk); #1;

        // Reset while a result for requester 0 is pending.
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        req_op[0] = ALU_ADD; req_a[0] = 32'd10; req_b[0] = 32'd20; req_tag[0] = 4'd1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("mid_pending", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 2'b11;
        @(negedge clk);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_op_count", op_count, 32'd0);
        check("mid_first_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
